// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem read, output register to decode.
// Grant N / rvalid N+1 gives if_valid in N+2; no request while the output is full and decode stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        id_ready
);

  typedef enum logic {S_FETCH, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_inflight_q, pc_inflight_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        valid_q, valid_d;
  logic        discard_q, discard_d;
  logic        fire;
  logic        handshake;
  logic        unused_bits;

  // Gating with rst_n keeps the request low while reset is held.
  assign imem_req    = rst_n && (state_q == S_FETCH) && (!valid_q || id_ready);
  assign imem_addr   = pc_q;
  assign fire        = imem_req && imem_gnt;
  assign handshake   = valid_q && id_ready;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;
  assign unused_bits = ^redirect_pc[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_inflight_d = pc_inflight_q;
    instr_d       = instr_q;
    if_pc_d       = if_pc_q;
    valid_d       = valid_q;
    discard_d     = discard_q;

    if (handshake) valid_d = 1'b0;

    if (state_q == S_FETCH) begin
      if (fire) begin
        pc_inflight_d = pc_q;
        pc_d          = pc_q + 32'd4;
        state_d       = S_WAIT;
      end
    end else if (imem_rvalid) begin
      state_d   = S_FETCH;
      discard_d = 1'b0;
      if (!discard_q) begin
        valid_d = 1'b1;
        instr_d = imem_rdata;
        if_pc_d = pc_inflight_q;
      end
    end

    // Redirect overrides the PC and flushes; an in-flight or just-granted read becomes wrong-path.
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      instr_d = instr_q;
      if_pc_d = if_pc_q;
      if ((state_q == S_WAIT) && !imem_rvalid) discard_d = 1'b1;
      if ((state_q == S_FETCH) && fire)        discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      pc_inflight_q <= 32'h0;
      instr_q       <= 32'h0;
      if_pc_q       <= 32'h0;
      valid_q       <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_inflight_q <= pc_inflight_d;
      instr_q       <= instr_d;
      if_pc_q       <= if_pc_d;
      valid_q       <= valid_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a PC-stream model.
module tb_fetch_unit;

  logic        clk, rst_n, redirect_valid, imem_gnt, imem_rvalid, id_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc, if_pc_plus4;

  int n_pass = 0;
  int n_total = 0;

  // Memory model state
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat_cfg;
  int          gnt_mode;
  bit          busy;
  bit          granted;
  logic [31:0] grant_addr;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .id_ready(id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  // One cycle: drive inputs after the falling edge, then sample and update the memory model.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    busy           = pend;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memfn(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_gnt = (gnt_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    granted    = imem_req && imem_gnt && rst_n;
    grant_addr = imem_addr;
    if (granted) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = ((lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg) - 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);
    n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", imem_req); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", if_valid); else n_pass++;
    n_total++; if (if_instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", if_instr); else n_pass++;
    n_total++; if (if_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", if_pc); else n_pass++;
    n_total++; if (if_pc_plus4 !== 32'h4) $display("FAIL reset_pc_plus4 got %h exp 4", if_pc_plus4); else n_pass++;
    rst_n = 1'b1;
    imem_gnt = 1'b0;
    pend = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    lat_cfg = 1; gnt_mode = 1;
    for (int k = 0; k <= 6; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      if (k == 0) begin
        n_total++; if (imem_req !== 1'b1) $display("FAIL stream_first_req got %b exp 1", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h100) $display("FAIL stream_first_addr got %h exp 100", imem_addr); else n_pass++;
      end else if (k % 2 == 0) begin
        e = 32'h100 + 32'(4 * (k / 2 - 1));
        n_total++; if (if_valid !== 1'b1) $display("FAIL stream_valid k=%0d got %b exp 1", k, if_valid); else n_pass++;
        n_total++; if (if_pc !== e) $display("FAIL stream_pc k=%0d got %h exp %h", k, if_pc, e); else n_pass++;
        n_total++; if (if_pc_plus4 !== e + 32'd4) $display("FAIL stream_plus4 k=%0d got %h exp %h", k, if_pc_plus4, e + 32'd4); else n_pass++;
        n_total++; if (if_instr !== memfn(e)) $display("FAIL stream_instr k=%0d got %h exp %h", k, if_instr, memfn(e)); else n_pass++;
      end else begin
        n_total++; if (if_valid !== 1'b0) $display("FAIL stream_gap k=%0d got %b exp 0", k, if_valid); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hpc, hin;
    bit found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      found = if_valid;
    end
    n_total++; if (!found) $display("FAIL bp_fill got no if_valid exp valid within 10 cycles"); else n_pass++;
    hpc = if_pc; hin = if_instr;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_total++; if (if_pc !== hpc || if_instr !== hin || if_valid !== 1'b1)
        $display("FAIL bp_hold c=%0d got pc %h instr %h v %b exp pc %h instr %h v 1", i, if_pc, if_instr, if_valid, hpc, hin); else n_pass++;
      n_total++; if (imem_req !== 1'b0) $display("FAIL bp_req c=%0d got %b exp 0", i, imem_req); else n_pass++;
    end
    tick(1'b1, 1'b0, 32'h0);
    n_total++; if (if_valid !== 1'b1) $display("FAIL bp_release_valid got %b exp 1", if_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== hpc + 32'd4)
      $display("FAIL bp_release_req got req %b addr %h exp req 1 addr %h", imem_req, imem_addr, hpc + 32'd4); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit found = 0, bad = 0, got_req = 0, got_out = 0;
    logic [31:0] req_a, out_pc, out_in;
    lat_cfg = 3;
    tick(1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      found = granted && (grant_addr == 32'h200);
    end
    n_total++; if (!found) $display("FAIL rw_grant got none exp grant of 00000200"); else n_pass++;
    tick(1'b1, 1'b1, 32'h403);
    for (int i = 0; i < 20 && !got_out; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      if (if_valid && if_pc == 32'h200) bad = 1;
      if (granted && !got_req) begin got_req = 1; req_a = grant_addr; end
      if (if_valid) begin got_out = 1; out_pc = if_pc; out_in = if_instr; end
    end
    n_total++; if (bad) $display("FAIL rw_drop got pc 00000200 delivered exp dropped"); else n_pass++;
    n_total++; if (!got_req || req_a !== 32'h400) $display("FAIL rw_next_addr got %h (seen %0d) exp 00000400", req_a, got_req); else n_pass++;
    n_total++; if (!got_out || out_pc !== 32'h400 || out_in !== memfn(32'h400))
      $display("FAIL rw_out got pc %h instr %h exp pc 00000400 instr %h", out_pc, out_in, memfn(32'h400)); else n_pass++;
  endtask

  task automatic test_redirect_rvalid();
    bit found = 0, got_out = 0;
    logic [31:0] out_pc;
    lat_cfg = 2;
    tick(1'b1, 1'b1, 32'h300);
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      found = granted && (grant_addr == 32'h300);
    end
    n_total++; if (!found) $display("FAIL rr_grant got none exp grant of 00000300"); else n_pass++;
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h80);
    tick(1'b1, 1'b0, 32'h0);
    n_total++; if (if_valid !== 1'b0) $display("FAIL rr_valid got %b exp 0", if_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80)
      $display("FAIL rr_next got req %b addr %h exp req 1 addr 00000080", imem_req, imem_addr); else n_pass++;
    for (int i = 0; i < 20 && !got_out; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      if (if_valid) begin got_out = 1; out_pc = if_pc; end
    end
    n_total++; if (!got_out || out_pc !== 32'h80) $display("FAIL rr_out got %h (seen %0d) exp 00000080", out_pc, got_out); else n_pass++;
  endtask

  task automatic test_redirect_flush();
    bit found = 0, got_out = 0;
    logic [31:0] out_pc;
    lat_cfg = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      found = if_valid;
    end
    n_total++; if (!found) $display("FAIL rf_fill got no if_valid exp valid"); else n_pass++;
    tick(1'b0, 1'b1, 32'h10);
    tick(1'b0, 1'b0, 32'h0);
    n_total++; if (if_valid !== 1'b0) $display("FAIL rf_flush got %b exp 0", if_valid); else n_pass++;
    for (int i = 0; i < 20 && !got_out; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      if (if_valid) begin got_out = 1; out_pc = if_pc; end
    end
    n_total++; if (!got_out || out_pc !== 32'h10) $display("FAIL rf_resume got %h (seen %0d) exp 00000010", out_pc, got_out); else n_pass++;
  endtask

  task automatic test_wrap();
    bit seen_top = 0, got_next = 0, seen_out = 0;
    logic [31:0] next_a, p4;
    lat_cfg = 1;
    tick(1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 20 && !(got_next && seen_out); i++) begin
      tick(1'b1, 1'b0, 32'h0);
      if (granted && grant_addr == 32'hFFFF_FFFC) seen_top = 1;
      else if (granted && seen_top && !got_next) begin got_next = 1; next_a = grant_addr; end
      if (if_valid && if_pc == 32'hFFFF_FFFC) begin seen_out = 1; p4 = if_pc_plus4; end
    end
    n_total++; if (!seen_top) $display("FAIL wrap_top got none exp grant of fffffffc"); else n_pass++;
    n_total++; if (!got_next || next_a !== 32'h0) $display("FAIL wrap_next got %h (seen %0d) exp 00000000", next_a, got_next); else n_pass++;
    n_total++; if (!seen_out || p4 !== 32'h0) $display("FAIL wrap_plus4 got %h (seen %0d) exp 00000000", p4, seen_out); else n_pass++;
  endtask

  task automatic test_midreset();
    bit found = 0, got_req = 0, got_out = 0;
    logic [31:0] req_a, out_pc, out_in;
    lat_cfg = 3;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      found = granted;
    end
    n_total++; if (!found) $display("FAIL mr_grant got none exp a grant"); else n_pass++;
    tick(1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    n_total++; if (if_valid !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL mr_async got valid %b req %b exp 0 0", if_valid, imem_req); else n_pass++;
    tick(1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    imem_gnt = 1'b0;
    for (int i = 0; i < 20 && !got_out; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      if (granted && !got_req) begin got_req = 1; req_a = grant_addr; end
      if (if_valid) begin got_out = 1; out_pc = if_pc; out_in = if_instr; end
    end
    n_total++; if (!got_req || req_a !== 32'h100) $display("FAIL mr_restart got %h (seen %0d) exp 00000100", req_a, got_req); else n_pass++;
    n_total++; if (!got_out || out_pc !== 32'h100 || out_in !== memfn(32'h100))
      $display("FAIL mr_out got pc %h instr %h exp pc 00000100 instr %h", out_pc, out_in, memfn(32'h100)); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, hpc, hin, rpc;
    bit hold = 0, rdy, rd;
    int ndel = 0;
    gnt_mode = 2; lat_cfg = 0;
    tick(1'b1, 1'b1, 32'h1000);
    exp_pc = 32'h1000;
    for (int c = 0; c < 2000; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 29) == 0);
      rpc = $urandom;
      tick(rdy, rd, rpc);
      if (busy) begin
        n_total++; if (imem_req !== 1'b0) $display("FAIL rnd_req_outstanding c=%0d got %b exp 0", c, imem_req); else n_pass++;
      end
      if (hold) begin
        n_total++; if (if_valid !== 1'b1 || if_pc !== hpc || if_instr !== hin)
          $display("FAIL rnd_hold c=%0d got v %b pc %h instr %h exp v 1 pc %h instr %h", c, if_valid, if_pc, if_instr, hpc, hin); else n_pass++;
      end
      if (if_valid && id_ready) begin
        n_total++; if (if_pc !== exp_pc) $display("FAIL rnd_pc c=%0d got %h exp %h", c, if_pc, exp_pc); else n_pass++;
        n_total++; if (if_instr !== memfn(exp_pc)) $display("FAIL rnd_instr c=%0d got %h exp %h", c, if_instr, memfn(exp_pc)); else n_pass++;
        n_total++; if (if_pc_plus4 !== exp_pc + 32'd4) $display("FAIL rnd_plus4 c=%0d got %h exp %h", c, if_pc_plus4, exp_pc + 32'd4); else n_pass++;
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end
      if (redirect_valid) exp_pc = {rpc[31:2], 2'b00};
      hold = if_valid && !id_ready && !redirect_valid;
      hpc = if_pc; hin = if_instr;
    end
    n_total++; if (ndel < 100) $display("FAIL rnd_progress got %0d deliveries exp at least 100", ndel); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0; lat_cfg = 1; gnt_mode = 1;
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_flush();
    test_wrap();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the architectural PC, issues single-outstanding word reads to instruction memory, and presents fetched instructions with their PC to decode through a valid/ready handshake. It sits directly upstream of the branch unit. It supplies `if_pc` as the branch unit's `pc_current`. It consumes the redirect (taken branch, `j`/`jal`/`jr`) computed downstream and flushes wrong-path fetches.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  one-cycle pulse; replace the PC with `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored and treated as 0.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word-aligned read address, valid while `imem_req`=1.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  read data valid, earliest 1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  output register holds an instruction.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc + 4`, modulo 2^32.
- `id_ready`  in  1  decode accepts the instruction when `if_valid && id_ready`.

## Operation
- Registers:
  - `pc_q`: next address to request.
  - `pc_inflight`: address of the outstanding request.
  - `discard`: drop the outstanding response.
  - Output register: `if_valid`, `if_instr`, `if_pc`.
- State machine with two states, reset state `FETCH`:
  - **FETCH**
    - `imem_req = !if_valid || id_ready`; `imem_addr = pc_q`.
    - On `imem_req && imem_gnt`: `pc_inflight <= pc_q`, `pc_q <= pc_q + 4` (wraps at 2^32), go to `WAIT`.
    - `imem_rvalid` is ignored in this state.
  - **WAIT**
    - `imem_req = 0`.
    - On `imem_rvalid` with `discard = 0`: load `if_instr <= imem_rdata`, `if_pc <= pc_inflight`, `if_valid <= 1`.
    - On `imem_rvalid` with `discard = 1`: drop the data, clear `discard`.
    - After `imem_rvalid` in either case, go to `FETCH`.
- Output register:
  - Cleared (`if_valid <= 0`) on handshake (`if_valid && id_ready`) unless reloaded the same cycle.
  - Holds its value while `if_valid && !id_ready`.
  - Requests are only issued when the register is empty or draining, so a response never overwrites an unconsumed instruction.
- Redirect (`redirect_valid = 1`) has priority over every other update:
  - `pc_q <= {redirect_pc[31:2], 2'b00}`; the +4 increment is suppressed.
  - `if_valid <= 0` (flush). A response arriving in the same cycle is not loaded.
  - In `WAIT` without `imem_rvalid`: set `discard <= 1`.
  - In `WAIT` with `imem_rvalid`: drop the data, go to `FETCH`, `discard` stays 0.
  - In `FETCH` with `imem_req && imem_gnt`: go to `WAIT` with `discard <= 1`.
  - In `FETCH` without grant: stay in `FETCH`. The memory permits `imem_addr` to change before grant.
- A second redirect while `discard = 1` only updates `pc_q`.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: `imem_req`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=4.
  - Internal: `pc_q`=`RESET_PC`, state `FETCH`, `discard`=0.
- First cycle after `rst_n` rises: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Reset during `WAIT`: the outstanding request is abandoned. A late `imem_rvalid` arrives in `FETCH` and is ignored.
- Latency:
  - Grant in cycle N, rvalid in cycle N+1: `if_valid`=1 in N+2.
  - Next request in N+2 if `id_ready`=1 or the output register is empty.
  - Peak throughput is 1 instruction per 2 cycles.
- Redirect in cycle N: next `imem_req` carrying `redirect_pc` appears in N+1 at the earliest, or once the discarded response returns.
- `imem_req`, `imem_addr` and `if_pc_plus4` are combinational from registers and `id_ready`. All other outputs are registered.

## Test plan
- **Reset and zero-wait stream:** `RESET_PC`=0x100, gnt always 1, rvalid 1 cycle after grant, `id_ready`=1 → decode receives pc 0x100, 0x104, 0x108 in cycles 2, 4, 6, with `if_pc_plus4` = pc+4.
- **Backpressure:** `id_ready`=0 for 5 cycles while `if_valid`=1 → `if_instr`/`if_pc` stable, `imem_req`=0. Raising `id_ready` → handshake and a new request the same cycle.
- **Redirect during WAIT:** request for 0x200 granted; `redirect_valid` with `redirect_pc`=0x403 before rvalid → the 0x200 data is dropped and never reaches `if_valid`. Next request address is 0x400.
- **Simultaneous redirect and rvalid:** rvalid for 0x300 in the same cycle as redirect to 0x80 → `if_valid` stays 0, next request is 0x80.
- **Redirect flushes output:** `if_valid`=1 with `id_ready`=0, redirect to 0x10 → `if_valid`=0 next cycle, fetch resumes at 0x10.
- **Wrap and mid-operation reset:**
  - PC 0xFFFF_FFFC is fetched, next request is 0x0.
  - Asserting `rst_n`=0 in `WAIT` then releasing → stale rvalid ignored, fetch restarts at `RESET_PC`.
